// File: rtl/parallel_adder_pkg.sv
// Shared constants for the 4-bit ripple-carry adder and its output register bank.
package parallel_adder_pkg;
   localparam int WIDTH = 4;
   // Output bank layout: {V, Cout, S[WIDTH-1:0]}
   localparam logic [WIDTH+1:0] RST_VAL = '0;
endpackage

// File: rtl/parallel_adder_if.sv
// Operand/result bundle between the adder pins and the registered datapath core.
import parallel_adder_pkg::*;

interface parallel_adder_if;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             v;

   modport master (output a, b, cin, input s, cout, v);
   modport slave  (input a, b, cin, output s, cout, v);
endinterface

// File: rtl/parallel_adder_core.sv
// Ripple chain of full adders, overflow detect and the synchronously reset output bank.
import parallel_adder_pkg::*;

module parallel_adder_core (
   input  logic           clk,
   input  logic           rst,
   parallel_adder_if.slave bus
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   assign carry[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
         .a    (bus.a[i]),
         .b    (bus.b[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   // Overflow: carry into the MSB disagrees with the carry out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         {bus.v, bus.cout, bus.s} <= RST_VAL;
      end else begin
         bus.s    <= sum;
         bus.cout <= carry[WIDTH];
         bus.v    <= carry[WIDTH-1] ^ carry[WIDTH];
      end
   end
endmodule

// File: rtl/parallel_adder_full_adder.sv
// One-bit combinational full adder, the stage of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/parallel_adder.sv
// 4-bit registered adder with per-bit pins; packs the pins into the bus feeding the core.
import parallel_adder_pkg::*;

module parallel_adder (
   input  logic clk,
   input  logic rst,
   input  logic A_1,
   input  logic A_2,
   input  logic A_3,
   input  logic A_4,
   input  logic B_1,
   input  logic B_2,
   input  logic B_3,
   input  logic B_4,
   input  logic Cin,
   output logic S_1,
   output logic S_2,
   output logic S_3,
   output logic S_4,
   output logic Cout,
   output logic V
);
   parallel_adder_if bus ();

   assign bus.a   = {A_4, A_3, A_2, A_1};
   assign bus.b   = {B_4, B_3, B_2, B_1};
   assign bus.cin = Cin;

   parallel_adder_core u_core (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   assign {S_4, S_3, S_2, S_1} = bus.s;
   assign Cout = bus.cout;
   assign V    = bus.v;
endmodule

// File: tb/tb_parallel_adder.sv
// Scoreboard bench for parallel_adder: expectations queued at drive time, checked one edge later.
module tb_parallel_adder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [5:0] sb[$];

   parallel_adder_if tb_bus ();

   always #5 clk = ~clk;

   parallel_adder dut (
      .clk  (clk),
      .rst  (rst),
      .A_1  (tb_bus.a[0]), .A_2 (tb_bus.a[1]), .A_3 (tb_bus.a[2]), .A_4 (tb_bus.a[3]),
      .B_1  (tb_bus.b[0]), .B_2 (tb_bus.b[1]), .B_3 (tb_bus.b[2]), .B_4 (tb_bus.b[3]),
      .Cin  (tb_bus.cin),
      .S_1  (tb_bus.s[0]), .S_2 (tb_bus.s[1]), .S_3 (tb_bus.s[2]), .S_4 (tb_bus.s[3]),
      .Cout (tb_bus.cout),
      .V    (tb_bus.v)
   );

   // Reference: {V, Cout, S} from integer addition and the sign-bit overflow rule.
   function automatic logic [5:0] model(input logic [3:0] a, b, input logic c, r);
      logic [4:0] t;
      logic       ov;
      if (r) return 6'd0;
      t  = {1'b0, a} + {1'b0, b} + {4'd0, c};
      ov = (a[3] == b[3]) && (t[3] != a[3]);
      return {ov, t};
   endfunction

   // Drive one operand set away from the edge, queue its expectation, step past the edge.
   task automatic apply(input logic [3:0] a, b, input logic c, r);
      @(negedge clk);
      tb_bus.a   = a;
      tb_bus.b   = b;
      tb_bus.cin = c;
      rst        = r;
      sb.push_back(model(a, b, c, r));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] exp, got;
      for (int i = 0; i < 2; i++) begin
         apply(4'hF, 4'hF, 1'b1, 1'b1);
         exp = sb.pop_front();
         got = {tb_bus.v, tb_bus.cout, tb_bus.s};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL reset[%0d]: got %b expected %b", i, got, exp);
         end
      end
   endtask

   task automatic test_directed();
      logic [8:0] vec [8];
      logic [5:0] req [8];
      logic [5:0] exp, got;
      vec = '{9'b0000_0000_0, 9'b0000_1111_0, 9'b1111_1111_0, 9'b1111_1111_1,
              9'b1111_0000_1, 9'b0111_0001_0, 9'b1000_1000_0, 9'b0101_0010_1};
      // Hand-derived {V, Cout, S}
      req = '{6'b00_0000, 6'b00_1111, 6'b01_1110, 6'b01_1111,
              6'b01_0000, 6'b10_1000, 6'b11_0000, 6'b10_1000};
      for (int i = 0; i < 8; i++) begin
         apply(vec[i][8:5], vec[i][4:1], vec[i][0], 1'b0);
         exp = sb.pop_front();
         got = {tb_bus.v, tb_bus.cout, tb_bus.s};
         tests++;
         if (got !== exp || exp !== req[i]) begin
            fails++;
            $display("FAIL directed[%0d] a=%b b=%b cin=%b: got %b expected %b (table %b)",
                     i, vec[i][8:5], vec[i][4:1], vec[i][0], got, exp, req[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp, got;
      logic [8:0] v;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         apply(v[8:5], v[4:1], v[0], (i == 200) || (i == 201));
         exp = sb.pop_front();
         got = {tb_bus.v, tb_bus.cout, tb_bus.s};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL sweep[%0d] a=%b b=%b cin=%b rst=%b: got %b expected %b",
                     i, v[8:5], v[4:1], v[0], rst, got, exp);
         end
      end
      // Operands 200/201 were dropped under reset; replay them fresh.
      for (int i = 200; i < 202; i++) begin
         v = 9'(i);
         apply(v[8:5], v[4:1], v[0], 1'b0);
         exp = sb.pop_front();
         got = {tb_bus.v, tb_bus.cout, tb_bus.s};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL replay[%0d]: got %b expected %b", i, got, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] exp, got;
      logic [3:0] a, b;
      logic       c, r;
      for (int i = 0; i < 64; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         c = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 9) == 0);
         apply(a, b, c, r);
         exp = sb.pop_front();
         got = {tb_bus.v, tb_bus.cout, tb_bus.s};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL random[%0d] a=%b b=%b cin=%b rst=%b: got %b expected %b",
                     i, a, b, c, r, got, exp);
         end
      end
   endtask

   initial begin
      tb_bus.a   = '0;
      tb_bus.b   = '0;
      tb_bus.cin = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/parallel_adder.md
# parallel_adder

4-bit ripple-carry parallel adder with registered outputs. It adds two 4-bit operands, presented as individual bit ports, plus a carry-in, and returns a 4-bit sum, carry-out and signed-overflow flag one clock after the operands are sampled. It serves as a standalone datapath arithmetic leaf and as a building block for wider adders: cascade Cout into the next stage's Cin.

## Interface
- Parameters: none; operand width is fixed at 4 bits.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- A_1  input  1  operand A bit 0 (LSB).
- A_2  input  1  operand A bit 1.
- A_3  input  1  operand A bit 2.
- A_4  input  1  operand A bit 3 (MSB).
- B_1  input  1  operand B bit 0 (LSB).
- B_2  input  1  operand B bit 1.
- B_3  input  1  operand B bit 2.
- B_4  input  1  operand B bit 3 (MSB).
- Cin  input  1  carry into bit 0.
- S_1  output  1  sum bit 0, registered.
- S_2  output  1  sum bit 1, registered.
- S_3  output  1  sum bit 2, registered.
- S_4  output  1  sum bit 3, registered.
- Cout  output  1  carry out of bit 3, registered.
- V  output  1  signed overflow, registered; V = carry into bit 3 XOR carry out of bit 3.

## Operation
- Combinational ripple chain of four full-adder stages; stage i uses A_i, B_i and the carry from stage i-1 (stage 1 uses Cin).
- Per stage: sum = a ^ b ^ c; carry = (a & b) | (c & (a ^ b)).
- Result equals {Cout, S_4..S_1} = A + B + Cin, unsigned, 5 bits; no saturation.
- Wrap-around: sums above 15 wrap modulo 16 with Cout = 1 (e.g. 15 + 0 + 1 gives S = 0, Cout = 1).
- V reports two's-complement overflow of the 4-bit result. V = 1 only when A_4 == B_4 and S_4 != A_4.
- No handshake: a new operand set is accepted every cycle.

## Timing
- Inputs are sampled on every rising clk edge; the results appear on the outputs after that edge (latency 1 cycle, throughput 1 per cycle).
- When rst is high at a rising edge, S_1..S_4, Cout and V all become 0, regardless of the inputs. Reset takes priority over data.
- Reset applied mid-stream discards the in-flight result. The first cycle after rst deasserts samples fresh inputs, so valid outputs appear one edge later.
- Outputs are X-free after the first reset edge. Before any reset they are undefined.
- Combinational path: the worst case is Cin to the S_4/Cout register inputs, 4 carry stages. It must meet one clk period.

## Structure
- Sub-module full_adder (a, b, cin -> s, cout), purely combinational, instantiated 4 times in a chain.
- The top-level holds the carry-chain wiring, the overflow XOR and the output register bank with synchronous reset.
- Shared package: a WIDTH = 4 constant and a reset-value constant (all zeros) for the output registers. No typedefs are required.

## Test plan
- Reset: assert rst for 2 cycles with A = 1111, B = 1111, Cin = 1 -> S = 0000, Cout = 0, V = 0 throughout reset.
- Zero and identity: A = 0000, B = 0000, Cin = 0 -> S = 0000, Cout = 0. A = 0000, B = 1111, Cin = 0 -> S = 1111, Cout = 0, V = 0. Each appears 1 cycle after sampling.
- Carry out: A = 1111, B = 1111, Cin = 0 -> S = 1110, Cout = 1, V = 0. With Cin = 1 -> S = 1111, Cout = 1.
- Full ripple and wrap: A = 1111, B = 0000, Cin = 1 -> S = 0000, Cout = 1, V = 0.
- Overflow: A = 0111, B = 0001, Cin = 0 -> S = 1000, Cout = 0, V = 1. A = 1000, B = 1000 -> S = 0000, Cout = 1, V = 1.
- Back-to-back and exhaustive: change operands every cycle across all 512 combinations of A, B and Cin. Each output must equal A + B + Cin of the previous cycle. Assert rst mid-sequence and check the outputs are zero on the next edge.
